// File: rtl/alu_reg_sequencer.sv
// alu_reg_sequencer: in-order RD/EX/WB sequencer for an external 4x32 regfile; define ALUSEQ_FIFO_EN for an input FIFO.

module ALU_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  alucontrol,
  output logic [31:0] result
);
  // Pure combinational datapath; op 100 is OR, unused codes return zero.
  always_comb
    result = alucontrol == 3'b000 ? a + b :
             alucontrol == 3'b001 ? a - b :
             alucontrol == 3'b010 ? a & b :
             alucontrol == 3'b011 ? a ^ b :
             alucontrol == 3'b100 ? a | b : '0;
endmodule

module alu_reg_sequencer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [8:0]  in_instr,
  output logic [1:0]  addr1,
  output logic [1:0]  addr2,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  output logic [1:0]  addr3,
  output logic [31:0] data3,
  output logic        wr,
  output logic        done,
  output logic [1:0]  done_rd,
  output logic [31:0] done_result,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, RD, EX, WB} state_t;

  state_t      state_q;
  logic [8:0]  instr_q;
  logic [31:0] a_q, b_q, res_q, alu_y;
  logic [1:0]  rd_q;
  logic        take, avail, queued;
  logic [8:0]  head;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end

  ALU_32 u_alu (.a(a_q), .b(b_q), .alucontrol(instr_q[8:6]), .result(alu_y));

  assign take = avail && (state_q == IDLE || state_q == WB);

`ifdef ALUSEQ_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [8:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  logic        push, empty, store, pop;
  // An empty FIFO is bypassed so a lone instruction keeps the idle latency.
  always_comb begin
    empty    = cnt_q == '0;
    in_ready = !rst && cnt_q != (AW+1)'(FIFO_DEPTH);
    push     = in_valid && in_ready;
    avail    = !empty || push;
    head     = empty ? in_instr : mem_q[rp_q];
    store    = push && !(take && empty);
    pop      = take && !empty;
    queued   = !empty;
  end
  // Pointer and occupancy bookkeeping; storage itself needs no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (store) wp_q <= wp_q + 1'b1;
      if (pop) rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(store) - (AW+1)'(pop);
    end
  end
  // FIFO storage write.
  always_ff @(posedge clk)
    if (store) mem_q[wp_q] <= in_instr;
`else
  // Without a FIFO only an idle sequencer accepts, straight into instr_q.
  always_comb begin
    in_ready = !rst && state_q == IDLE;
    avail    = in_valid && in_ready;
    head     = in_instr;
    queued   = 1'b0;
  end
`endif

  // Sequencer FSM: IDLE -> RD -> EX -> WB, chaining directly into RD when work is waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      instr_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= take ? RD : state_q == RD ? EX : state_q == EX ? WB : IDLE;
      if (take) instr_q <= head;
      if (state_q == EX) begin
        a_q <= data1;
        b_q <= data2;
      end
      if (state_q == WB) begin
        res_q <= alu_y;
        rd_q  <= instr_q[5:4];
      end
    end
  end

  // Writeback outputs show the live result in WB and hold it afterwards.
  always_comb begin
    addr1       = instr_q[3:2];
    addr2       = instr_q[1:0];
    addr3       = state_q == WB ? instr_q[5:4] : rd_q;
    data3       = state_q == WB ? alu_y : res_q;
    wr          = state_q == WB && !rst;
    done        = wr;
    done_rd     = addr3;
    done_result = data3;
    busy        = state_q != IDLE || queued;
  end
endmodule

// File: tb/tb_alu_reg_sequencer.sv
// tb_alu_reg_sequencer: random and directed stimulus against an architectural regfile model.

module tb_alu_reg_sequencer;
  localparam int FIFO_DEPTH = 4;

  logic        clk = 0, rst, in_valid, in_ready;
  logic [8:0]  in_instr;
  logic [1:0]  addr1, addr2, addr3, done_rd;
  logic [31:0] data1, data2, data3, done_result;
  logic        wr, done, busy;

  logic [31:0] rf [4];
  logic [31:0] ref_r [4];

  typedef struct { logic [8:0] ins; int acc; } ent_t;
  ent_t q[$];

  int cyc = 0, last_wr = -100, n_acc = 0, n_done = 0;
  int n_vec = 0, n_err = 0;
  bit saw_full = 0;

  alu_reg_sequencer #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .addr1(addr1), .addr2(addr2), .data1(data1), .data2(data2),
    .addr3(addr3), .data3(data3), .wr(wr), .done(done),
    .done_rd(done_rd), .done_result(done_result), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign data1 = rf[addr1];
  assign data2 = rf[addr2];
  always @(posedge clk) if (wr) rf[addr3] <= data3;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      default: return a ^ b;
    endcase
  endfunction

  // Scoreboard: every accept is queued; each write must match the next queued instruction
  // evaluated on the architectural state, no earlier than 3 cycles after accept and 3 after the previous write.
  always @(negedge clk) begin
    if (rst) begin
      check("wr_in_rst", {31'b0, wr}, 0);
      n_acc   = n_acc - q.size();
      q.delete();
      last_wr = -100;
    end else begin
      check("busy", {31'b0, busy}, {31'b0, q.size() != 0});
`ifdef ALUSEQ_FIFO_EN
      if (q.size() == 0) check("in_ready_empty", {31'b0, in_ready}, 1);
      if (in_valid && !in_ready) saw_full = 1;
`else
      check("in_ready", {31'b0, in_ready}, {31'b0, q.size() == 0});
`endif
      if (wr) begin
        if (q.size() == 0) check("spurious_wr", {31'b0, wr}, 0);
        else begin
          ent_t e;
          logic [31:0] exp;
          int ec;
          e   = q.pop_front();
          exp = ref_op(e.ins[8:6], ref_r[e.ins[3:2]], ref_r[e.ins[1:0]]);
          ec  = (e.acc + 3 > last_wr + 3) ? e.acc + 3 : last_wr + 3;
          check("wr_cycle", cyc, ec);
          check("addr3", {30'b0, addr3}, {30'b0, e.ins[5:4]});
          check("data3", data3, exp);
          check("done", {31'b0, done}, 1);
          check("done_rd", {30'b0, done_rd}, {30'b0, e.ins[5:4]});
          check("done_result", done_result, exp);
          ref_r[e.ins[5:4]] = exp;
          last_wr = cyc;
          n_done++;
        end
      end else check("done_idle", {31'b0, done}, 0);
      if (in_valid && in_ready) begin
        q.push_back('{in_instr, cyc});
        n_acc++;
      end
    end
  end

  task automatic rf_init();
    rf[0] = 32'h0;        rf[1] = 32'h9ABCDEF0; rf[2] = 32'hFFFFFFFF; rf[3] = 32'h00000001;
    for (int i = 0; i < 4; i++) ref_r[i] = rf[i];
  endtask

  task automatic send(input logic [8:0] ins);
    bit acc = 0;
    in_valid = 1;
    in_instr = ins;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    check("send_accept", {31'b0, acc}, 1);
  endtask

  task automatic drain();
    in_valid = 0;
    for (int n = 0; n < 300 && q.size() != 0; n++) @(posedge clk);
    #1;
    check("drain_empty", 32'(q.size()), 0);
    for (int i = 0; i < 4; i++) check("rf_vs_model", rf[i], ref_r[i]);
  endtask

  function automatic logic [8:0] rand_instr();
    logic [8:0] r;
    r = 9'($urandom);
    r[8:6] = 3'($urandom_range(0, 3));
    return r;
  endfunction

  initial begin
    rst = 1; in_valid = 0; in_instr = '0;
    rf_init();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_addr", {26'b0, addr1, addr2, addr3}, 0);
    check("rst_data3", data3, 0);
    check("rst_done_rd", {30'b0, done_rd}, 0);
    check("rst_done_result", done_result, 0);
    @(posedge clk); #1 rst = 0;

    send(9'b000_00_01_10);
    drain();
    check("single_add", rf[0], 32'h9ABCDEEF);

    rf_init();
    send(9'b000_00_01_10);
    send(9'b010_01_10_11);
    send(9'b011_11_10_00);
    send(9'b001_10_01_11);
    drain();
    check("chain_r0", rf[0], 32'h9ABCDEEF);
    check("chain_r1", rf[1], 32'h00000001);
    check("chain_r2", rf[2], 32'h9ABCDEF1);
    check("chain_r3", rf[3], 32'h65432110);

    rf_init();
    for (int i = 0; i < FIFO_DEPTH + 2; i++) send(rand_instr());
    drain();
`ifdef ALUSEQ_FIFO_EN
    check("fifo_full_seen", {31'b0, saw_full}, 1);
`endif

    rf_init();
    send(9'b000_01_01_01);
    in_valid = 0;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("mid_rst_busy", {31'b0, busy}, 0);
    check("mid_rst_outs", {26'b0, addr1, addr2, addr3}, 0);
    check("mid_rst_data3", data3, 0);
    check("mid_rst_r1", rf[1], 32'h9ABCDEF0);
    send(9'b000_00_01_11);
    drain();
    check("post_rst_r0", rf[0], 32'h9ABCDEF1);

    rf_init();
    send(9'b001_10_10_10);
    drain();
    check("self_operand", rf[2], 32'h0);

    for (int i = 0; i < 40; i++) begin
      in_valid = 0;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1;
        in_instr = rand_instr();
        @(posedge clk); #1;
        in_valid = 0;
      end
      send(rand_instr());
    end
    drain();
    check("done_count", n_done, n_acc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
